// File: rtl/mdio_mgmt_master.sv
// Clause-22 MDIO management master: serialises one read/write frame per accepted
// command on MDC/MDIO and returns read data / turnaround status with a one-clk rsp_valid.
module mdio_mgmt_master #(
   parameter int MDC_HALF_DIV = 4,
   parameter int PRE_LEN      = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic        cmd_write,
   input  logic [4:0]  cmd_phyad,
   input  logic [4:0]  cmd_regad,
   input  logic [15:0] cmd_wdata,
   output logic        rsp_valid,
   output logic [15:0] rsp_rdata,
   output logic        rsp_ta_err,
   output logic        busy,
   output logic        mdc,
   output logic        mdio_o,
   output logic        mdio_oe,
   input  logic        mdio_i
);
   typedef enum logic [2:0] {IDLE, PRE, HDR, TA, DATA, DONE} state_t;

   localparam logic [7:0] H_LAST = 8'(MDC_HALF_DIV - 1);
   localparam logic [5:0] B_HDR  = 6'(PRE_LEN);
   localparam logic [5:0] B_TA   = 6'(PRE_LEN + 14);
   localparam logic [5:0] B_TA2  = 6'(PRE_LEN + 15);
   localparam logic [5:0] B_DATA = 6'(PRE_LEN + 16);
   localparam logic [5:0] B_LAST = 6'(PRE_LEN + 31);

   state_t      state;
   logic [7:0]  hcnt;
   logic [5:0]  bcnt;
   logic [63:0] sreg;
   logic        wr;
   logic        ta;
   logic [15:0] rx;
   logic [63:0] frame_ld;
   logic [5:0]  bnext;
   logic        drive_next;

   // Whole frame left-aligned: preamble ones, then ST/OP/PHYAD/REGAD/TA/DATA.
   always_comb begin
      frame_ld = {32'hFFFF_FFFF, 2'b01, (cmd_write ? 2'b01 : 2'b10), cmd_phyad, cmd_regad,
                  2'b10, (cmd_write ? cmd_wdata : 16'hFFFF)} << (32 - PRE_LEN);
      bnext      = bcnt + 6'd1;
      drive_next = wr | (bnext < B_TA);
   end

   assign cmd_ready = (state == IDLE);
   assign busy      = ~cmd_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mdc        <= 1'b0;
         mdio_o     <= 1'b1;
         mdio_oe    <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_rdata  <= 16'h0;
         rsp_ta_err <= 1'b0;
         hcnt       <= 8'h0;
         bcnt       <= 6'h0;
         sreg       <= 64'h0;
         wr         <= 1'b0;
         ta         <= 1'b0;
         rx         <= 16'h0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  state   <= (PRE_LEN > 0) ? PRE : HDR;
                  wr      <= cmd_write;
                  mdc     <= 1'b0;
                  mdio_o  <= frame_ld[63];
                  mdio_oe <= 1'b1;
                  sreg    <= frame_ld << 1;
                  hcnt    <= 8'h0;
                  bcnt    <= 6'h0;
                  ta      <= 1'b0;
                  rx      <= 16'h0;
               end
            end
            DONE: state <= IDLE;
            default: begin
               if (hcnt != H_LAST) begin
                  hcnt <= hcnt + 8'd1;
               end else begin
                  hcnt <= 8'h0;
                  if (!mdc) begin
                     mdc <= 1'b1;
                  end else begin
                     mdc <= 1'b0;
                     // Sample on the last clk of the high half, just before MDC falls.
                     if (!wr) begin
                        if (bcnt == B_TA2) ta <= mdio_i;
                        if (bcnt >= B_DATA) rx <= {rx[14:0], mdio_i};
                     end
                     if (bcnt == B_LAST) begin
                        state      <= DONE;
                        mdio_oe    <= 1'b0;
                        mdio_o     <= 1'b1;
                        rsp_valid  <= 1'b1;
                        rsp_rdata  <= wr ? 16'h0 : {rx[14:0], mdio_i};
                        rsp_ta_err <= wr ? 1'b0 : ta;
                     end else begin
                        bcnt    <= bnext;
                        mdio_o  <= drive_next ? sreg[63] : 1'b1;
                        mdio_oe <= drive_next;
                        sreg    <= sreg << 1;
                        if (bnext == B_HDR)       state <= HDR;
                        else if (bnext == B_TA)   state <= TA;
                        else if (bnext == B_DATA) state <= DATA;
                     end
                  end
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mdio_mgmt_master.sv
// Bench for mdio_mgmt_master: default instance checked frame-by-frame against a
// scoreboard, plus a D=2/no-preamble instance for back-to-back command timing.
module tb_mdio_mgmt_master;
   localparam int D = 4;
   localparam int PRE = 32;
   localparam int N = PRE + 32;

   logic clk = 0, rst = 1;
   logic cmd_valid = 0, cmd_write = 0, mdio_i = 1;
   logic [4:0] cmd_phyad = 0, cmd_regad = 0;
   logic [15:0] cmd_wdata = 0;
   logic cmd_ready, rsp_valid, rsp_ta_err, busy, mdc, mdio_o, mdio_oe;
   logic [15:0] rsp_rdata;

   logic b_valid = 0;
   logic b_ready, b_rsp_valid, b_ta_err, b_busy, b_mdc, b_mdio_o, b_mdio_oe, b_mdio_i;
   logic [15:0] b_rdata;
   assign b_mdio_i = b_mdio_oe ? b_mdio_o : 1'b1;

   int cyc = 0, n_chk = 0, n_err = 0;

   typedef struct {logic [15:0] rd; logic ta; int acc;} exp_t;
   exp_t sbq[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mdio_mgmt_master #(.MDC_HALF_DIV(D), .PRE_LEN(PRE)) u_dut (
      .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_phyad(cmd_phyad), .cmd_regad(cmd_regad), .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_ta_err(rsp_ta_err), .busy(busy), .mdc(mdc), .mdio_o(mdio_o),
      .mdio_oe(mdio_oe), .mdio_i(mdio_i));

   mdio_mgmt_master #(.MDC_HALF_DIV(2), .PRE_LEN(0)) u_dut_b (
      .clk(clk), .rst(rst), .cmd_valid(b_valid), .cmd_ready(b_ready), .cmd_write(1'b1),
      .cmd_phyad(5'h03), .cmd_regad(5'h07), .cmd_wdata(16'hBEEF), .rsp_valid(b_rsp_valid),
      .rsp_rdata(b_rdata), .rsp_ta_err(b_ta_err), .busy(b_busy), .mdc(b_mdc), .mdio_o(b_mdio_o),
      .mdio_oe(b_mdio_oe), .mdio_i(b_mdio_i));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Scoreboard: every rsp_valid must match the oldest outstanding command.
   always @(negedge clk) begin
      if (rsp_valid) begin
         if (sbq.size() == 0) chk("rsp_unexpected", 1, 0);
         else begin
            exp_t e;
            e = sbq.pop_front();
            chk("rsp_rdata", rsp_rdata, e.rd);
            chk("rsp_ta_err", rsp_ta_err, e.ta);
            chk("rsp_latency", cyc - e.acc, 513);
         end
      end
   end

   task automatic issue(input logic wr, input logic [4:0] phy, input logic [4:0] rg,
                        input logic [15:0] wd, output int acc);
      int t = 0;
      @(negedge clk);
      while (!cmd_ready && t < 2000) begin @(negedge clk); t++; end
      if (!cmd_ready) chk("ready_timeout", 0, 1);
      cmd_valid = 1; cmd_write = wr; cmd_phyad = phy; cmd_regad = rg; cmd_wdata = wd;
      acc = cyc;
      @(posedge clk); #1;
      // Fields are don't-care after accept: scramble them.
      cmd_valid = 0; cmd_write = ~wr; cmd_phyad = 5'($urandom);
      cmd_regad = 5'($urandom); cmd_wdata = 16'($urandom);
   endtask

   // Follows one frame cycle by cycle, acting as the MDIO pad + responder.
   task automatic watch(input logic resp_en, input logic [15:0] rdat,
                        output logic [63:0] obs, output logic [63:0] oe_obs);
      int k, ph, bad = 0;
      obs = 0; oe_obs = 0;
      for (int c = 1; c <= 2 * D * N; c++) begin
         @(negedge clk);
         k = (c - 1) / (2 * D);
         ph = (c - 1) % (2 * D);
         if (mdc !== (ph >= D)) bad++;
         if (mdio_oe) mdio_i = mdio_o;
         else if (resp_en && k == PRE + 15) mdio_i = 1'b0;
         else if (resp_en && k >= PRE + 16) mdio_i = rdat[15 - (k - PRE - 16)];
         else mdio_i = 1'b1;
         if (ph == 2 * D - 1) begin
            obs[63 - k] = mdio_o;
            oe_obs[63 - k] = mdio_oe;
         end
      end
      chk("mdc_waveform_errs", bad, 0);
      @(negedge clk);
      mdio_i = 1;
      chk("done_mdc", mdc, 0);
      chk("done_oe", mdio_oe, 0);
      chk("done_busy", busy, 1);
      @(negedge clk);
      chk("idle_ready", cmd_ready, 1);
   endtask

   initial begin
      int acc, idle_bad, na, nr;
      int accs[2], rsps[2];
      logic [63:0] obs, oe_obs;
      exp_t e;

      repeat (3) @(negedge clk);
      chk("rst_mdc", mdc, 0);
      chk("rst_oe", mdio_oe, 0);
      chk("rst_mdio_o", mdio_o, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rdata", rsp_rdata, 0);
      chk("rst_ta_err", rsp_ta_err, 0);
      rst = 0;
      @(negedge clk);
      chk("rst_ready", cmd_ready, 1);
      chk("rst_busy", busy, 0);

      // Write with exact frame pattern
      issue(1, 5'h01, 5'h05, 16'hA5C3, acc);
      e.rd = 16'h0; e.ta = 0; e.acc = acc; sbq.push_back(e);
      watch(0, 16'h0, obs, oe_obs);
      chk("wr_pattern", obs, 64'hFFFF_FFFF_5096_A5C3);
      chk("wr_oe", oe_obs, 64'hFFFF_FFFF_FFFF_FFFF);

      idle_bad = 0;
      repeat (20) begin @(negedge clk); if (mdc !== 1'b0) idle_bad++; end
      chk("idle_mdc_toggles", idle_bad, 0);

      // Read with a live responder
      issue(0, 5'h01, 5'h10, 16'hFFFF, acc);
      e.rd = 16'h1234; e.ta = 0; e.acc = acc; sbq.push_back(e);
      watch(1, 16'h1234, obs, oe_obs);
      chk("rd_hdr", obs[63:18], {32'hFFFF_FFFF, 14'b01_10_00001_10000});
      chk("rd_oe_bit45", oe_obs[63 - 45], 1);
      chk("rd_oe_tail", oe_obs[63 - 47:0], 0);

      // Read with MDIO floating
      issue(0, 5'h02, 5'h03, 16'h0, acc);
      e.rd = 16'hFFFF; e.ta = 1; e.acc = acc; sbq.push_back(e);
      watch(0, 16'h0, obs, oe_obs);

      // Reset mid-frame: no response may appear for the aborted write
      issue(1, 5'h04, 5'h06, 16'h5A5A, acc);
      while (cyc < acc + 200) @(negedge clk);
      rst = 1;
      @(negedge clk);
      chk("abort_mdc", mdc, 0);
      chk("abort_oe", mdio_oe, 0);
      chk("abort_ready", cmd_ready, 1);
      chk("abort_rsp", rsp_valid, 0);
      rst = 0;
      issue(1, 5'h01, 5'h05, 16'hA5C3, acc);
      e.rd = 16'h0; e.ta = 0; e.acc = acc; sbq.push_back(e);
      watch(0, 16'h0, obs, oe_obs);
      chk("post_abort_pattern", obs, 64'hFFFF_FFFF_5096_A5C3);

      // Back-to-back on the fast instance, cmd_valid held high throughout
      na = 0; nr = 0;
      @(negedge clk);
      b_valid = 1;
      for (int i = 0; i < 400 && nr < 2; i++) begin
         if (b_rsp_valid) begin
            if (nr < 2) rsps[nr] = cyc;
            nr++;
            chk("b_rdata", b_rdata, 0);
         end
         if (b_valid && b_ready) begin
            if (na < 2) accs[na] = cyc;
            na++;
            if (na == 2) begin @(posedge clk); #1 b_valid = 0; end
         end
         @(negedge clk);
      end
      b_valid = 0;
      chk("b_accepts", na, 2);
      chk("b_responses", nr, 2);
      if (na == 2 && nr == 2) begin
         chk("b_second_accept", accs[1] - accs[0], 130);
         chk("b_lat0", rsps[0] - accs[0], 129);
         chk("b_lat1", rsps[1] - accs[1], 129);
      end

      repeat (5) @(negedge clk);
      chk("sb_empty", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end
endmodule
